id_scoreboard: RTL and testbench

Parametrised register scoreboard and forwarding-select unit for the decode stage of the LoongArch pipeline. It tracks every in-flight architectural register write with a per-register pending counter and holds a busy counter for the multi-cycle divider. Each cycle it reports which of NUM_FWD bypass sources, or the regfile, feeds each of up to three source operands, and whether decode must stall. It replaces the fixed three-stage EXE/MEM/WB compare logic in decode and lets long-latency units without a bypass bus hold registers safely.

---
 rtl/id_scoreboard_if.sv | 38 +++
 rtl/id_scoreboard.sv | 118 +++++++++++
 tb/tb_id_scoreboard.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_scoreboard_if.sv
// Decode-stage scoreboard bundle: source operands, bypass status, issue/retire
// handshakes and the resulting forward selects and stall.
interface id_scoreboard_if #(
  parameter int NUM_FWD = 3,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
);
  logic [14:0]          src_addr;
  logic [2:0]           src_use;
  logic [5*NUM_FWD-1:0] fwd_dest;
  logic [NUM_FWD-1:0]   fwd_wen;
  logic [NUM_FWD-1:0]   fwd_rdy;
  logic [3*SEL_W-1:0]   fwd_sel;
  logic                 issue_valid;
  logic [4:0]           issue_dest;
  logic                 issue_wen;
  logic                 issue_div;
  logic                 issue_fire;
  logic                 stall;
  logic                 retire_valid;
  logic [4:0]           retire_dest;
  logic                 cancel;
  logic                 div_busy;
  logic                 sb_err;

  modport master (
    output src_addr, src_use, fwd_dest, fwd_wen, fwd_rdy,
           issue_valid, issue_dest, issue_wen, issue_div,
           retire_valid, retire_dest, cancel,
    input  fwd_sel, issue_fire, stall, div_busy, sb_err
  );

  modport slave (
    input  src_addr, src_use, fwd_dest, fwd_wen, fwd_rdy,
           issue_valid, issue_dest, issue_wen, issue_div,
           retire_valid, retire_dest, cancel,
    output fwd_sel, issue_fire, stall, div_busy, sb_err
  );
endinterface

// File: rtl/id_scoreboard.sv
// Register scoreboard and forwarding-select unit: per-register pending write
// counters, divider occupancy counter, bypass selection and decode stall.
module id_scoreboard #(
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = 2,
  parameter int DIV_LAT = 8,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic           clk,
  input  logic           reset,
  id_scoreboard_if.slave sb
);
  localparam int DIV_W = $clog2(DIV_LAT + 1);

  logic [CNT_W-1:0] pending_r [1:31];
  logic [DIV_W-1:0] div_cnt_r;
  logic             sb_err_r;

  logic [CNT_W-1:0] pend_s [32];
  logic [SEL_W-1:0] sel_s  [3];
  logic [2:0]       src_haz_s;
  logic             hit_s;
  logic             hit_rdy_s;
  logic [4:0]       src_s;
  logic             full_haz_s;
  logic             div_haz_s;
  logic             stall_s;
  logic             issue_fire_s;
  logic [31:1]      inc_s;
  logic [31:1]      ret_s;
  logic             err_s;

  // r0 reads as an always-empty counter so lookups need no special case
  always_comb begin
    pend_s[0] = '0;
    for (int i = 1; i < 32; i++) begin
      pend_s[i] = pending_r[i];
    end
  end

  // Per-source bypass match (lowest index wins) and operand hazard
  always_comb begin
    hit_s     = 1'b0;
    hit_rdy_s = 1'b0;
    src_s     = 5'd0;
    for (int s = 0; s < 3; s++) begin
      src_s     = sb.src_addr[5*s +: 5];
      sel_s[s]  = '0;
      hit_s     = 1'b0;
      hit_rdy_s = 1'b0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (sb.fwd_wen[k] && (sb.fwd_dest[5*k +: 5] == src_s) && (src_s != 5'd0)) begin
          sel_s[s]  = SEL_W'(k + 1);
          hit_s     = 1'b1;
          hit_rdy_s = sb.fwd_rdy[k];
        end else begin
          sel_s[s]  = sel_s[s];
        end
      end
      src_haz_s[s] = sb.src_use[s] && (pend_s[src_s] != '0) && (!hit_s || !hit_rdy_s);
    end
  end

  // Structural hazards, stall and per-register update strobes
  always_comb begin
    full_haz_s   = sb.issue_wen && (sb.issue_dest != 5'd0) &&
                   (pend_s[sb.issue_dest] == {CNT_W{1'b1}});
    div_haz_s    = sb.issue_div && (div_cnt_r != '0);
    stall_s      = sb.issue_valid && ((|src_haz_s) || full_haz_s || div_haz_s);
    issue_fire_s = sb.issue_valid && !stall_s;
    for (int i = 1; i < 32; i++) begin
      inc_s[i] = issue_fire_s && sb.issue_wen && (sb.issue_dest == 5'(i));
      ret_s[i] = sb.retire_valid && (sb.retire_dest == 5'(i));
    end
    err_s = sb.retire_valid && (sb.retire_dest != 5'd0) && (pend_s[sb.retire_dest] == '0);
  end

  // Pending counters, divider occupancy and sticky error; cancel keeps sb_err
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        pending_r[i] <= '0;
      end
      div_cnt_r <= '0;
      sb_err_r  <= 1'b0;
    end else if (sb.cancel) begin
      for (int i = 1; i < 32; i++) begin
        pending_r[i] <= '0;
      end
      div_cnt_r <= '0;
      sb_err_r  <= sb_err_r | err_s;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (inc_s[i] && !ret_s[i]) begin
          pending_r[i] <= pending_r[i] + 1'b1;
        end else if (ret_s[i] && !inc_s[i] && (pending_r[i] != '0)) begin
          pending_r[i] <= pending_r[i] - 1'b1;
        end else begin
          pending_r[i] <= pending_r[i];
        end
      end
      if (issue_fire_s && sb.issue_div) begin
        div_cnt_r <= DIV_W'(DIV_LAT);
      end else if (div_cnt_r != '0) begin
        div_cnt_r <= div_cnt_r - 1'b1;
      end else begin
        div_cnt_r <= div_cnt_r;
      end
      sb_err_r <= sb_err_r | err_s;
    end
  end

  assign sb.fwd_sel    = {sel_s[2], sel_s[1], sel_s[0]};
  assign sb.stall      = stall_s;
  assign sb.issue_fire = issue_fire_s;
  assign sb.div_busy   = (div_cnt_r != '0);
  assign sb.sb_err     = sb_err_r;
endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: per-cycle vector table plus hand-written
// sequences for divider occupancy, counter saturation, sb_err, cancel and r0.
module tb_id_scoreboard;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  id_scoreboard_if #(.NUM_FWD(3)) sbi ();

  id_scoreboard #(.NUM_FWD(3), .CNT_W(2), .DIV_LAT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sbi)
  );

  typedef struct {
    logic [14:0] sa;
    logic [2:0]  su;
    logic [14:0] fd;
    logic [2:0]  fw;
    logic [2:0]  fr;
    logic        iv;
    logic [4:0]  id;
    logic        iw;
    logic        idv;
    logic        rv;
    logic [4:0]  rd;
    logic [9:0]  exp; // {fwd_sel, stall, issue_fire, div_busy, sb_err}
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic [14:0] sa, input logic [2:0] su,
                              input logic [14:0] fd, input logic [2:0] fw,
                              input logic [2:0] fr, input logic iv,
                              input logic [4:0] id, input logic iw, input logic idv,
                              input logic rv, input logic [4:0] rd,
                              input logic [5:0] sel, input logic st, input logic fi,
                              input logic bu, input logic er);
    vec_t v;
    v.sa = sa; v.su = su; v.fd = fd; v.fw = fw; v.fr = fr;
    v.iv = iv; v.id = id; v.iw = iw; v.idv = idv; v.rv = rv; v.rd = rd;
    v.exp = {sel, st, fi, bu, er};
    return v;
  endfunction

  task automatic clr();
    sbi.src_addr = 15'd0; sbi.src_use = 3'd0; sbi.fwd_dest = 15'd0;
    sbi.fwd_wen = 3'd0; sbi.fwd_rdy = 3'd0; sbi.issue_valid = 1'b0;
    sbi.issue_dest = 5'd0; sbi.issue_wen = 1'b0; sbi.issue_div = 1'b0;
    sbi.retire_valid = 1'b0; sbi.retire_dest = 5'd0; sbi.cancel = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [4:0] dest, input logic wen, input logic div);
    clr();
    sbi.issue_valid = 1'b1; sbi.issue_dest = dest;
    sbi.issue_wen = wen; sbi.issue_div = div;
  endtask

  task automatic wait_idle_div();
    int n = 0;
    clr();
    while (sbi.div_busy && n < 20) begin
      tick();
      n++;
    end
    check("div_idle_wait", 32'(sbi.div_busy), 32'd0);
  endtask

  initial begin
    // fwd_dest is packed {bypass2, bypass1, bypass0}
    tbl[0]  = mk(15'd0, 3'b000, 15'd0, 3'b000, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(15'd0, 3'b000, 15'd0, 3'b000, 3'b000, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[2]  = mk(15'd5, 3'b001, {5'd7, 5'd5, 5'd5}, 3'b011, 3'b111, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 6'b000001, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[3]  = mk(15'd5, 3'b001, {5'd7, 5'd5, 5'd5}, 3'b000, 3'b111, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(15'd0, 3'b000, 15'd0, 3'b000, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(15'd5, 3'b001, 15'd0, 3'b000, 3'b000, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[6]  = mk(15'd0, 3'b000, 15'd0, 3'b000, 3'b000, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk({5'd0, 5'd9, 5'd0}, 3'b010, {5'd0, 5'd0, 5'd9}, 3'b001, 3'b000, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 6'b000100, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk({5'd0, 5'd9, 5'd0}, 3'b010, {5'd0, 5'd0, 5'd9}, 3'b001, 3'b001, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 6'b000100, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mk({5'd0, 5'd9, 5'd0}, 3'b000, {5'd0, 5'd0, 5'd9}, 3'b001, 3'b000, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 6'b000100, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[10] = mk(15'd0, 3'b000, 15'd0, 3'b000, 3'b000, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[11] = mk(15'd4, 3'b001, 15'd0, 3'b000, 3'b000, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[12] = mk(15'd4, 3'b001, 15'd0, 3'b000, 3'b000, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[13] = mk(15'd4, 3'b001, 15'd0, 3'b000, 3'b000, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0);

    clr();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      sbi.src_addr = tbl[i].sa; sbi.src_use = tbl[i].su; sbi.fwd_dest = tbl[i].fd;
      sbi.fwd_wen = tbl[i].fw; sbi.fwd_rdy = tbl[i].fr; sbi.issue_valid = tbl[i].iv;
      sbi.issue_dest = tbl[i].id; sbi.issue_wen = tbl[i].iw; sbi.issue_div = tbl[i].idv;
      sbi.retire_valid = tbl[i].rv; sbi.retire_dest = tbl[i].rd; sbi.cancel = 1'b0;
      #1;
      check($sformatf("vec%0d", i),
            32'({sbi.fwd_sel, sbi.stall, sbi.issue_fire, sbi.div_busy, sbi.sb_err}),
            32'(tbl[i].exp));
      tick();
    end

    // Divider structural hazard: second div held for exactly DIV_LAT cycles
    wait_idle_div();
    issue(5'd0, 1'b0, 1'b1);
    #1;
    check("div_first_fire", 32'(sbi.issue_fire), 32'd1);
    tick();
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("div_hold_t%0d", c), 32'({sbi.stall, sbi.div_busy}), 32'b11);
    end
    tick();
    for (int c = 2; c <= 8; c++) begin
      check($sformatf("div_hold2_t%0d", c), 32'({sbi.stall, sbi.div_busy}), 32'b11);
      tick();
    end
    check("div_second_fire", 32'({sbi.issue_fire, sbi.div_busy}), 32'b10);
    tick();

    // Counter saturation on r3
    for (int w = 1; w <= 3; w++) begin
      issue(5'd3, 1'b1, 1'b0);
      #1;
      check($sformatf("sat_write%0d", w), 32'(sbi.issue_fire), 32'd1);
      tick();
    end
    issue(5'd3, 1'b1, 1'b0);
    sbi.retire_valid = 1'b1; sbi.retire_dest = 5'd3;
    #1;
    check("sat_write4_stall", 32'({sbi.stall, sbi.issue_fire}), 32'b10);
    tick();
    issue(5'd3, 1'b1, 1'b0);
    #1;
    check("sat_refill_fire", 32'(sbi.issue_fire), 32'd1);
    tick();
    issue(5'd3, 1'b1, 1'b0);
    #1;
    check("sat_full_again", 32'(sbi.stall), 32'd1);
    tick();

    // Retire of an empty register sets sticky sb_err
    clr();
    sbi.retire_valid = 1'b1; sbi.retire_dest = 5'd6;
    #1;
    check("err_before_edge", 32'(sbi.sb_err), 32'd0);
    tick();
    clr();
    #1;
    check("err_set", 32'(sbi.sb_err), 32'd1);
    tick();
    check("err_sticky", 32'(sbi.sb_err), 32'd1);

    // Cancel with r1 pending twice and divider busy, plus a same-cycle issue to r1
    wait_idle_div();
    issue(5'd1, 1'b1, 1'b1);
    #1;
    check("cancel_setup1", 32'(sbi.issue_fire), 32'd1);
    tick();
    issue(5'd1, 1'b1, 1'b0);
    #1;
    check("cancel_setup2", 32'(sbi.issue_fire), 32'd1);
    tick();
    issue(5'd1, 1'b1, 1'b0);
    sbi.cancel = 1'b1;
    #1;
    check("cancel_cycle_busy", 32'(sbi.div_busy), 32'd1);
    tick();
    clr();
    sbi.issue_valid = 1'b1;
    sbi.src_addr = {5'd0, 5'd3, 5'd1};
    sbi.src_use = 3'b011;
    #1;
    check("cancel_cleared", 32'({sbi.stall, sbi.issue_fire, sbi.div_busy}), 32'b010);
    check("cancel_keeps_err", 32'(sbi.sb_err), 32'd1);
    tick();

    // r0 is never tracked and never forwarded
    issue(5'd0, 1'b1, 1'b0);
    #1;
    check("r0_issue", 32'(sbi.issue_fire), 32'd1);
    tick();
    clr();
    sbi.issue_valid = 1'b1; sbi.src_addr = 15'd0; sbi.src_use = 3'b001;
    sbi.fwd_dest = 15'd0; sbi.fwd_wen = 3'b001; sbi.fwd_rdy = 3'b000;
    #1;
    check("r0_read", 32'({sbi.fwd_sel, sbi.stall}), 32'd0);
    tick();

    // Reset mid-divide drops div_busy and clears sb_err
    issue(5'd0, 1'b0, 1'b1);
    tick();
    clr();
    #1;
    check("pre_reset_busy", 32'(sbi.div_busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("post_reset", 32'({sbi.div_busy, sbi.sb_err}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
